ptw_mem_responder: RTL and testbench

PTW_MEM_RESPONDER -- requirements
Module: ptw_mem_responder

---
 rtl/mmu_pkg.sv | 52 +++++
 rtl/ptw_mem_responder.sv | 126 ++++++++++++
 tb/tb_ptw_mem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU types and constants for the PTW memory responder.
package mmu_pkg;

  // Width of the address field carried in the PTW request struct.
  localparam int unsigned PTW_ADDR_W = 40;

  localparam logic [4:0] M_XRD   = 5'b00000;
  localparam logic [4:0] M_XA_OR = 5'b01010;
  localparam logic [3:0] MT_D    = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RESP,
    NACK
  } ptw_mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  phys;
    logic [4:0]            cmd;
    logic [3:0]            typ;
    logic [PTW_ADDR_W-1:0] addr;
    logic                  kill;
    logic [63:0]           data;
  } ptw_req_t;

  typedef struct packed {
    ptw_req_t req;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic        valid;
    logic        nack;
    logic [63:0] data;
  } dmem_resp_t;

  typedef struct packed {
    logic       dmem_ready;
    dmem_resp_t resp;
  } dmem_ptw_comm_t;

  // A request the responder cannot serve: only aligned physical doubleword reads/OR-AMOs.
  function automatic logic ptw_req_unsupported(input ptw_req_t r);
    return !((r.cmd == M_XRD) || (r.cmd == M_XA_OR)) || (r.typ != MT_D) ||
           !r.phys || (r.addr[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/ptw_mem_responder.sv
// PTW memory responder: serves page-table-walker doubleword reads and OR-AMOs
// (used to set A/D bits) against a simple req/gnt/rvalid backing memory.
// Optional build macro PTW_MEM_TIMEOUT_EN adds a per-state timeout that nacks
// the walker when the backing memory stalls for TIMEOUT_CYCLES cycles.
module ptw_mem_responder
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 40,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ptw_dmem_comm_t    ptw_dmem_comm_i,
  output dmem_ptw_comm_t    dmem_ptw_comm_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i,
  input  logic              mem_err_i
);

  ptw_mem_state_e    r_state;
  logic [4:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_data;
  logic [63:0]       r_rdata;

  logic w_bad;
  logic w_tmo;

  assign w_bad = ptw_req_unsupported(ptw_dmem_comm_i.req);

`ifdef PTW_MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] r_tmo_cnt;
  logic            w_counting;
  logic            w_advance;

  assign w_counting = (r_state == RD_REQ) || (r_state == RD_WAIT) ||
                      (r_state == WR_REQ) || (r_state == WR_WAIT);
  // Any handshake that moves the FSM on is a state entry and restarts the count.
  assign w_advance  = (((r_state == RD_REQ) || (r_state == WR_REQ)) && mem_gnt_i) ||
                      (((r_state == RD_WAIT) || (r_state == WR_WAIT)) && mem_rvalid_i);
  assign w_tmo      = w_counting && (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in the current memory-waiting state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (!w_counting || w_advance || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Request FSM; a handshake completing in the final timeout cycle still wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (ptw_dmem_comm_i.req.valid && !ptw_dmem_comm_i.req.kill) begin
            r_cmd   <= ptw_dmem_comm_i.req.cmd;
            r_addr  <= ADDR_W'(ptw_dmem_comm_i.req.addr);
            r_data  <= ptw_dmem_comm_i.req.data;
            r_state <= w_bad ? NACK : RD_REQ;
          end
        end
        RD_REQ: begin
          if (mem_gnt_i)  r_state <= RD_WAIT;
          else if (w_tmo) r_state <= NACK;
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              r_state <= NACK;
            end else begin
              r_rdata <= mem_rdata_i;
              r_state <= (r_cmd == M_XA_OR) ? WR_REQ : RESP;
            end
          end else if (w_tmo) begin
            r_state <= NACK;
          end
        end
        WR_REQ: begin
          if (mem_gnt_i)  r_state <= WR_WAIT;
          else if (w_tmo) r_state <= NACK;
        end
        WR_WAIT: begin
          if (mem_rvalid_i) r_state <= mem_err_i ? NACK : RESP;
          else if (w_tmo)   r_state <= NACK;
        end
        RESP:    r_state <= IDLE;
        NACK:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state flops; ready is gated so it stays low in reset.
  always_comb begin
    dmem_ptw_comm_o            = '0;
    dmem_ptw_comm_o.dmem_ready = (r_state == IDLE) && !rst_i;
    dmem_ptw_comm_o.resp.valid = (r_state == RESP);
    dmem_ptw_comm_o.resp.nack  = (r_state == NACK);
    dmem_ptw_comm_o.resp.data  = r_rdata;
    mem_req_o                  = (r_state == RD_REQ) || (r_state == WR_REQ);
    mem_we_o                   = (r_state == WR_REQ);
    mem_addr_o                 = r_addr;
    mem_wdata_o                = r_rdata | r_data;
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Self-checking bench for ptw_mem_responder: reset checks, directed vector
// table, mid-operation reset, optional timeout, and randomized transactions
// checked against a transaction-level reference model.
module tb_ptw_mem_responder;
  import mmu_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  ptw_dmem_comm_t ptw_in;
  dmem_ptw_comm_t dmem_out;
  logic           mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [39:0]    mem_addr;
  logic [63:0]    mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ptw_mem_responder #(
    .ADDR_W         (40),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ptw_dmem_comm_i (ptw_in),
    .dmem_ptw_comm_o (dmem_out),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_gnt_i       (mem_gnt),
    .mem_rvalid_i    (mem_rvalid),
    .mem_rdata_i     (mem_rdata),
    .mem_err_i       (mem_err)
  );

  // One transaction: request fields, memory behaviour, expected outcome.
  // exp_kind: 0 no response, 1 resp.valid, 2 resp.nack.
  // exp_lat: cycles from the accepting cycle (cycle 0) to the response cycle.
  typedef struct {
    logic [4:0]  cmd;
    logic [3:0]  typ;
    logic        phys;
    logic [39:0] addr;
    logic        kill;
    logic [63:0] data;
    logic [63:0] mem;
    int          g0, r0, g1, r1;
    logic        e0, e1;
    int          exp_kind;
    logic [63:0] exp_data;
    int          exp_lat;
    int          exp_nops;
    logic [63:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] cmd, input logic [3:0] typ, input logic phys,
                               input logic [39:0] addr, input logic kill, input logic [63:0] data,
                               input logic [63:0] mem, input int g0, input int r0, input int g1,
                               input int r1, input logic e0, input logic e1, input int kind,
                               input logic [63:0] edata, input int lat, input int nops,
                               input logic [63:0] wdata);
    vec_t v;
    v.cmd = cmd; v.typ = typ; v.phys = phys; v.addr = addr; v.kill = kill; v.data = data;
    v.mem = mem; v.g0 = g0; v.r0 = r0; v.g1 = g1; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.exp_kind = kind; v.exp_data = edata; v.exp_lat = lat; v.exp_nops = nops;
    v.exp_wdata = wdata;
    return v;
  endfunction

  // Reference model: outcome and timeline from the request rules and memory delays.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int   rd_gnt, rd_done, wr_gnt, wr_done;
    logic legal;
    v = vin;
    v.exp_kind = 0; v.exp_data = '0; v.exp_lat = 0; v.exp_nops = 0;
    v.exp_wdata = v.mem | v.data;
    legal = (v.cmd == 5'b00000 || v.cmd == 5'b01010) && v.typ == 4'b0011 && v.phys &&
            (v.addr % 8 == 0);
    if (v.kill) return v;
    if (!legal) begin
      v.exp_kind = 2; v.exp_lat = 1;
      return v;
    end
    v.exp_nops = 1;
    rd_gnt  = 1 + v.g0;
    rd_done = rd_gnt + 1 + v.r0;
    if (v.e0) begin
      v.exp_kind = 2; v.exp_lat = rd_done + 1;
    end else if (v.cmd == 5'b00000) begin
      v.exp_kind = 1; v.exp_data = v.mem; v.exp_lat = rd_done + 1;
    end else begin
      v.exp_nops = 2;
      wr_gnt  = rd_done + 1 + v.g1;
      wr_done = wr_gnt + 1 + v.r1;
      v.exp_kind = v.e1 ? 2 : 1;
      v.exp_data = v.e1 ? 64'h0 : v.mem;
      v.exp_lat  = wr_done + 1;
    end
    return v;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"},  dmem_out.dmem_ready, 0);
    chk({tag, "_valid"},  dmem_out.resp.valid, 0);
    chk({tag, "_nack"},   dmem_out.resp.nack, 0);
    chk({tag, "_rdata"},  dmem_out.resp.data, 0);
    chk({tag, "_req"},    mem_req, 0);
    chk({tag, "_we"},     mem_we, 0);
    chk({tag, "_addr"},   mem_addr, 0);
    chk({tag, "_wdata"},  mem_wdata, 0);
  endtask

  // Drive one transaction with a cycle-level memory agent and compare to v.
  task automatic run_vec(input vec_t v, input string tag);
    int          lim, got_edge, n_resp, nobs, gcnt, rcnt, k, unstable, not_ready, both;
    logic        got, got_valid, in_op, pend, ready_after, rv, rn;
    logic [63:0] got_data, t;
    logic        ow[2];
    logic [39:0] oa[2];
    logic [63:0] od[2];
    got = 0; got_valid = 0; got_data = '0; got_edge = -1; n_resp = 0; nobs = 0;
    gcnt = 0; rcnt = 0; k = 0; unstable = 0; not_ready = 0; both = 0;
    in_op = 0; pend = 0; ready_after = 0;
    lim = (v.exp_kind == 0) ? 12 : v.exp_lat + 8;
    for (int w = 0; w < 20 && !dmem_out.dmem_ready; w++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_ready_in"}, dmem_out.dmem_ready, 1);
    ptw_in.req.valid = 1'b1; ptw_in.req.phys = v.phys; ptw_in.req.cmd = v.cmd;
    ptw_in.req.typ = v.typ; ptw_in.req.addr = v.addr; ptw_in.req.kill = v.kill;
    ptw_in.req.data = v.data;
    @(posedge clk); #1;
    ptw_in.req.valid = 1'b0;
    for (int e = 0; e < lim; e++) begin
      rv = dmem_out.resp.valid;
      rn = dmem_out.resp.nack;
      if (rv && rn) both++;
      if (rv || rn) begin
        n_resp++;
        if (!got) begin
          got = 1; got_valid = rv; got_data = dmem_out.resp.data; got_edge = e;
        end
      end
      if (got && e == got_edge + 1) ready_after = dmem_out.dmem_ready;
      if (!dmem_out.dmem_ready) not_ready++;
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
      if (pend) begin
        if (rcnt == 0) begin
          t = {$urandom, $urandom};
          mem_rvalid = 1; mem_err = (k == 0) ? v.e0 : v.e1;
          mem_rdata = (k == 0) ? v.mem : t;
          pend = 0; k++;
        end else rcnt--;
      end else if (mem_req) begin
        if (!in_op) begin
          in_op = 1;
          if (nobs < 2) begin
            ow[nobs] = mem_we; oa[nobs] = mem_addr; od[nobs] = mem_wdata;
          end
          nobs++;
          gcnt = (k == 0) ? v.g0 : v.g1;
        end else if (nobs <= 2) begin
          if (mem_we !== ow[nobs-1] || mem_addr !== oa[nobs-1] || mem_wdata !== od[nobs-1])
            unstable++;
        end
        if (gcnt == 0) begin
          mem_gnt = 1; in_op = 0; pend = 1; rcnt = (k == 0) ? v.r0 : v.r1;
        end else gcnt--;
      end else if ($urandom_range(3) == 0) begin
        mem_rvalid = 1; mem_err = 1'($urandom_range(1)); mem_rdata = {$urandom, $urandom};
      end
      // Request noise while busy must be ignored.
      if (!dmem_out.dmem_ready && $urandom_range(1) == 1) begin
        t = {$urandom, $urandom};
        ptw_in.req.valid = 1; ptw_in.req.cmd = t[4:0]; ptw_in.req.typ = t[8:5];
        ptw_in.req.phys = t[9]; ptw_in.req.kill = t[10]; ptw_in.req.addr = t[63:24];
        ptw_in.req.data = {$urandom, $urandom};
      end else begin
        ptw_in.req.valid = 0;
      end
      if (got && e == got_edge + 1) break;
      @(posedge clk); #1;
    end
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; ptw_in.req.valid = 0;
    chk({tag, "_kind"}, got ? (got_valid ? 1 : 2) : 0, v.exp_kind);
    chk({tag, "_both"}, both, 0);
    chk({tag, "_nresp"}, n_resp, (v.exp_kind != 0) ? 1 : 0);
    if (v.exp_kind == 1) chk({tag, "_data"}, got_data, v.exp_data);
    if (v.exp_kind != 0) begin
      chk({tag, "_lat"}, got_edge + 1, v.exp_lat);
      chk({tag, "_ready_after"}, ready_after, 1);
    end else begin
      chk({tag, "_busy"}, not_ready, 0);
    end
    chk({tag, "_nops"}, nobs, v.exp_nops);
    for (int i = 0; i < 2; i++) begin
      if (i < nobs && i < v.exp_nops) begin
        chk({tag, $sformatf("_op%0d_we", i)}, ow[i], (i == 1) ? 1 : 0);
        chk({tag, $sformatf("_op%0d_addr", i)}, oa[i], v.addr);
        if (i == 1) chk({tag, "_op1_wdata"}, od[i], v.exp_wdata);
      end
    end
    chk({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    vec_t        v;
    logic [63:0] t;
    int          n_rsp, n_req, n_nrdy, nack_edge, n_val, req_cyc;

    tbl[0] = mkv(5'b00000, 4'b0011, 1, 40'h80001000, 0, 64'h0, 64'h200000CF, 0, 0, 0, 0, 0, 0,
                 1, 64'h200000CF, 3, 1, 64'h0);
    tbl[1] = mkv(5'b01010, 4'b0011, 1, 40'h80001000, 0, 64'hC0, 64'h2000000F, 0, 0, 0, 0, 0, 0,
                 1, 64'h2000000F, 5, 2, 64'h200000CF);
    tbl[2] = mkv(5'b00000, 4'b0010, 1, 40'h80001000, 0, 64'h0, 64'h1, 0, 0, 0, 0, 0, 0,
                 2, 64'h0, 1, 0, 64'h0);
    tbl[3] = mkv(5'b00000, 4'b0011, 1, 40'h80001004, 0, 64'h0, 64'h1, 0, 0, 0, 0, 0, 0,
                 2, 64'h0, 1, 0, 64'h0);
    tbl[4] = mkv(5'b01010, 4'b0011, 1, 40'h80001000, 0, 64'hC0, 64'h2000000F, 0, 0, 0, 0, 0, 1,
                 2, 64'h0, 5, 2, 64'h200000CF);
    tbl[5] = mkv(5'b00000, 4'b0011, 1, 40'h80001000, 1, 64'h0, 64'h5, 0, 0, 0, 0, 0, 0,
                 0, 64'h0, 0, 0, 64'h0);
    tbl[6] = mkv(5'b00000, 4'b0011, 0, 40'h80001000, 0, 64'h0, 64'h5, 0, 0, 0, 0, 0, 0,
                 2, 64'h0, 1, 0, 64'h0);
    tbl[7] = mkv(5'b00001, 4'b0011, 1, 40'h80001000, 0, 64'h0, 64'h5, 0, 0, 0, 0, 0, 0,
                 2, 64'h0, 1, 0, 64'h0);
    tbl[8] = mkv(5'b00000, 4'b0011, 1, 40'h80002008, 0, 64'h0, 64'h77, 0, 0, 0, 0, 1, 0,
                 2, 64'h0, 3, 1, 64'h0);
    tbl[9] = mkv(5'b00000, 4'b0011, 1, 40'h80003010, 0, 64'h0, 64'hDEADBEEF, 2, 3, 0, 0, 0, 0,
                 1, 64'hDEADBEEF, 8, 1, 64'h0);

    rst = 1'b1; ptw_in = '0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release_ready", dmem_out.dmem_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset while waiting for read data: nothing may come out afterwards.
    ptw_in.req.valid = 1; ptw_in.req.phys = 1; ptw_in.req.cmd = 5'b01010;
    ptw_in.req.typ = 4'b0011; ptw_in.req.addr = 40'h80004000; ptw_in.req.kill = 0;
    ptw_in.req.data = 64'hC0;
    @(posedge clk); #1;
    ptw_in.req.valid = 0;
    chk("mrst_req", mem_req, 1);
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    rst = 1'b1;
    #1;
    chk_quiet("mrst_inreset");
    @(posedge clk); #1;
    rst = 1'b0;
    n_rsp = 0; n_req = 0; n_nrdy = 0;
    for (int c = 0; c < 6; c++) begin
      mem_rvalid = 1; mem_err = 0; mem_rdata = 64'h1234;
      @(posedge clk); #1;
      if (dmem_out.resp.valid || dmem_out.resp.nack) n_rsp++;
      if (mem_req) n_req++;
      if (!dmem_out.dmem_ready) n_nrdy++;
    end
    mem_rvalid = 0;
    chk("mrst_resp", n_rsp, 0);
    chk("mrst_memreq", n_req, 0);
    chk("mrst_ready", n_nrdy, 0);

`ifdef PTW_MEM_TIMEOUT_EN
    // Memory never grants: nack after 8 cycles of RD_REQ, late rvalid ignored.
    ptw_in.req.valid = 1; ptw_in.req.phys = 1; ptw_in.req.cmd = 5'b00000;
    ptw_in.req.typ = 4'b0011; ptw_in.req.addr = 40'h80005000; ptw_in.req.kill = 0;
    @(posedge clk); #1;
    ptw_in.req.valid = 0;
    nack_edge = -1; n_val = 0; req_cyc = 0; n_rsp = 0;
    for (int e = 0; e < 30; e++) begin
      if (mem_req) req_cyc++;
      if (dmem_out.resp.nack) begin
        n_rsp++;
        if (nack_edge < 0) nack_edge = e;
      end
      if (dmem_out.resp.valid) n_val++;
      mem_gnt = 0;
      mem_rvalid = (nack_edge >= 0);
      mem_rdata = 64'h55;
      @(posedge clk); #1;
    end
    mem_rvalid = 0;
    chk("tmo_req_cycles", req_cyc, 8);
    chk("tmo_nack_cycle", nack_edge, 8);
    chk("tmo_nack_count", n_rsp, 1);
    chk("tmo_no_valid", n_val, 0);
    chk("tmo_ready", dmem_out.dmem_ready, 1);
`endif

    for (int i = 0; i < 150; i++) begin
      t = {$urandom, $urandom};
      case ($urandom_range(9))
        0, 1, 2, 3: v.cmd = 5'b00000;
        4, 5, 6, 7: v.cmd = 5'b01010;
        default:    v.cmd = t[4:0];
      endcase
      v.typ  = ($urandom_range(7) == 0) ? t[8:5] : 4'b0011;
      v.phys = ($urandom_range(7) != 0);
      v.addr = t[63:24];
      if ($urandom_range(7) != 0) v.addr[2:0] = 3'b000;
      v.kill = ($urandom_range(15) == 0);
      v.data = {$urandom, $urandom};
      v.mem  = {$urandom, $urandom};
      v.g0 = $urandom_range(4); v.r0 = $urandom_range(4);
      v.g1 = $urandom_range(4); v.r1 = $urandom_range(4);
      v.e0 = ($urandom_range(7) == 0);
      v.e1 = ($urandom_range(7) == 0);
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
